divider: RTL
============

# divider

Sequential unsigned 64-by-32 divider: the inverse of the ALU's 32x32 shift-add multiplier. It takes a 64-bit dividend, such as a multiplier product, and a 32-bit divisor. It returns a 32-bit quotient and a 32-bit remainder, producing one quotient bit per clock with the restoring algorithm. It is the ALU's divide path and is driven by a start/done handshake from the ALU control.

## Interface
- No parameters; widths fixed (dividend 64, divisor/quotient/remainder 32).
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk, accepted only when busy=0
- Z  input  64  dividend, captured on accepted start
- B  input  32  divisor, captured on accepted start
- Q  output  32  quotient, registered
- R  output  32  remainder, registered
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when Q/R/flags are valid
- div_by_zero  output  1  registered flag, B==0 on last accepted operation
- overflow  output  1  registered flag, quotient does not fit in 32 bits (B!=0 and Z[63:32] >= B)

## Operation
- Internal regs: rem[31:0], q[31:0], b[31:0], cnt[5:0], state.
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE or DONE, start=1 (accept):
  - capture b=B, rem=Z[63:32], q=Z[31:0], cnt=0.
  - clear div_by_zero/overflow.
  - If B==0: set div_by_zero=1, Q=32'hFFFFFFFF, R=Z[31:0], go DONE.
  - Else if Z[63:32] >= B: set overflow=1, Q=32'hFFFFFFFF, R=Z[31:0], go DONE.
  - Else go RUN.
- IDLE or DONE, start=0: go IDLE (from DONE) / stay IDLE.
- RUN, per cycle:
  - t = {rem, q[31]} (33 bits).
  - If t >= {1'b0,b}: rem = (t - b)[31:0], qbit=1; else rem = t[31:0], qbit=0.
  - q = {q[30:0], qbit}; cnt = cnt+1.
  - On the iteration where cnt==31: load Q=new q, R=new rem, go DONE.
- Invariant rem < b holds throughout RUN, so a 33-bit compare/subtract suffices.
- Q, R, div_by_zero and overflow hold their values until the next accepted start updates them.
- start while busy=1 is ignored; there is no queueing.

## Timing
- Reset values: Q=0, R=0, busy=0, done=0, div_by_zero=0, overflow=0, state=IDLE.
- Normal divide, start accepted at edge 0:
  - busy=1 from edge 0 to edge 32.
  - 32 iterations at edges 1..32.
  - Edge 32: Q/R valid, done=1, busy=0.
  - Edge 33: done=0.
  - Latency is 32 cycles start->done.
- div_by_zero/overflow: the start edge loads results and enters DONE, so done=1 the cycle after start (latency 1). busy stays 0 throughout.
- done is high for exactly one cycle per accepted start.
- start=1 while in DONE is accepted, allowing back-to-back operation. done drops on that edge and busy rises (or done re-pulses for an exception case).
- rst_n low at any time, including mid-RUN: all outputs and state return to reset values immediately (async). No done is produced for the aborted operation. Operation resumes on the first edge after rst_n deasserts.
- Z and B may change freely after the start edge; only the captured values are used.

## Test plan
- Z=64'd100, B=7, start 1 cycle -> busy for 32 cycles, done pulse at edge 32, Q=14, R=2, both flags 0.
- Z=64'hFFFFFFFE00000001, B=32'hFFFFFFFF -> Q=32'hFFFFFFFF, R=0, overflow=0, latency 32.
- Z=64'h0000000000001234, B=0 -> done the cycle after start, div_by_zero=1, Q=32'hFFFFFFFF, R=32'h1234, busy never high.
- Z=64'h0000000500000000, B=5 -> overflow=1, done after 1 cycle, Q=32'hFFFFFFFF, R=0.
- Start Z=1000, B=3; pulse start with new operands at cycle 5 (ignored); assert rst_n=0 at cycle 10 -> all outputs 0, no done. Re-issue after reset -> Q=333, R=1 at 32 cycles.
- Back-to-back: start (Z=50, B=8), then start (Z=81, B=9) during the done cycle -> first Q=6, R=2; second done 32 cycles later with Q=9, R=0.

Source files
------------

// File: rtl/divider_if.sv
// divider_if: operand, result and handshake signals between the ALU control
// (master) and the sequential 64-by-32 divider (slave).
interface divider_if;
    logic        start;
    logic [63:0] Z;
    logic [31:0] B;
    logic [31:0] Q;
    logic [31:0] R;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, Z, B,
        input  Q, R, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, Z, B,
        output Q, R, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/divider.sv
// divider: sequential unsigned 64-by-32 restoring divider, one quotient bit
// per clock. The divide-by-zero and quotient-overflow cases are resolved on
// the accepting edge and finish in a single cycle.
module divider (
    input  logic       clk,
    input  logic       rst_n,
    divider_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] rem;
    logic [31:0] q;
    logic [31:0] b;
    logic [5:0]  cnt;

    logic [32:0] t;
    logic        take;
    logic [31:0] rem_next;
    logic [31:0] q_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor whenever it fits. Because rem < b
    // always holds, the 33-bit trial value never needs more than 32 bits
    // once the divisor has been subtracted.
    always_comb begin
        t        = {rem, q[31]};
        take     = (t >= {1'b0, b});
        rem_next = take ? (t[31:0] - b) : t[31:0];
        q_next   = {q[30:0], take};
    end

    // Control FSM with registered results, flags and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rem             <= '0;
            q               <= '0;
            b               <= '0;
            cnt             <= '0;
            bus.Q           <= '0;
            bus.R           <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        b               <= bus.B;
                        rem             <= bus.Z[63:32];
                        q               <= bus.Z[31:0];
                        cnt             <= '0;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b0;
                        if (bus.B == 32'd0) begin
                            bus.div_by_zero <= 1'b1;
                            bus.Q           <= 32'hFFFF_FFFF;
                            bus.R           <= bus.Z[31:0];
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end else if (bus.Z[63:32] >= bus.B) begin
                            bus.overflow <= 1'b1;
                            bus.Q        <= 32'hFFFF_FFFF;
                            bus.R        <= bus.Z[31:0];
                            bus.done     <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bus.busy <= 1'b1;
                            state    <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    q   <= q_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        bus.Q    <= q_next;
                        bus.R    <= rem_next;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule
